// File: rtl/wbk_stage.sv
// Writeback stage: retires mem2wbk heads, joining multiplier results, onto a registered RF write port.
// Latency 1 retire->WBK_*; pops combinational; a mult head with an empty multiplier FIFO stalls both FIFOs.
module wbk_stage #(
  parameter int MULT_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MEM2WBK_EMPTY_SM,
  input  logic [31:0] MEM_RES_RM,
  input  logic [5:0]  MEM_DEST_RM,
  input  logic        WB_RM,
  input  logic        CSR_WENABLE_RM,
  input  logic [31:0] CSR_RDATA_RM,
  input  logic        MULT_INST_RM,
  output logic        MEM2WBK_POP_SW,
  input  logic        MULT_EMPTY_SX,
  input  logic [31:0] MULT_RES_RX,
  output logic        MULT_POP_SW,
  input  logic        FLUSH_SI,
  output logic [31:0] WBK_DATA_SW,
  output logic [5:0]  WBK_DEST_SW,
  output logic        WBK_WB_SW,
  output logic        WBK_STALL_SW,
  output logic        MULT_TIMEOUT_SW,
  output logic [63:0] MINSTRET_SW
);

  typedef enum logic {RUN = 1'b0, WAIT_MULT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] C_TO_M1 = CNT_W'(MULT_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic            r_timeout;
  logic [31:0]     r_data;
  logic [5:0]      r_dest;
  logic            r_wb;
  logic [63:0]     r_minstret;

  logic            w_hv;
  logic            w_stall;
  logic            w_stall_nf;
  logic            w_retire;
  logic [31:0]     w_wdata;

  assign w_hv       = !MEM2WBK_EMPTY_SM;
  assign w_stall    = reset_n & w_hv & MULT_INST_RM & MULT_EMPTY_SX;
  assign w_stall_nf = w_stall & !FLUSH_SI;
  // Flush dominates retire; reset also holds the pops low.
  assign w_retire   = reset_n & w_hv & !FLUSH_SI & (!MULT_INST_RM | !MULT_EMPTY_SX);

  assign MEM2WBK_POP_SW  = w_retire;
  assign MULT_POP_SW     = w_retire & MULT_INST_RM;
  assign WBK_STALL_SW    = w_stall;
  assign WBK_DATA_SW     = r_data;
  assign WBK_DEST_SW     = r_dest;
  assign WBK_WB_SW       = r_wb;
  assign MULT_TIMEOUT_SW = r_timeout;
  assign MINSTRET_SW     = r_minstret;

  always_comb begin
    w_wdata = MEM_RES_RM;
    if (CSR_WENABLE_RM)    w_wdata = CSR_RDATA_RM;
    else if (MULT_INST_RM) w_wdata = MULT_RES_RX;
  end

  // WAIT_MULT is held only while the head keeps stalling; anything else returns to RUN.
  always_comb begin
    w_state_nxt = RUN;
    case (r_state)
      RUN:       if (w_stall_nf) w_state_nxt = WAIT_MULT;
      WAIT_MULT: if (w_stall_nf) w_state_nxt = WAIT_MULT;
      default:   w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_data     <= '0;
      r_dest     <= '0;
      r_wb       <= 1'b0;
      r_minstret <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (FLUSH_SI || r_state == RUN) r_cnt <= '0;
      else if (r_cnt != '1)          r_cnt <= r_cnt + 1'b1;

      if (FLUSH_SI)
        r_timeout <= 1'b0;
      else if (r_state == WAIT_MULT && w_stall_nf && r_cnt == C_TO_M1)
        r_timeout <= 1'b1;

      if (w_retire) begin
        r_data     <= w_wdata;
        r_dest     <= MEM_DEST_RM;
        r_wb       <= (WB_RM | CSR_WENABLE_RM) & (MEM_DEST_RM != 6'd0);
        r_minstret <= r_minstret + 64'd1;
      end else begin
        r_wb <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wbk_stage.md
Name: wbk_stage

Overview:
- Writeback stage directly downstream of the memory stage; sole consumer of the mem2wbk FIFO.
- Merges memory/ALU results with results from the multiplier result FIFO (entries tagged MULT_INST), then drives the register-file write port through a registered output.
- Keeps a 64-bit retired-instruction counter and flags a stalled multiplier with a watchdog.

Parameters:
- MULT_TIMEOUT, 64: cycles spent in WAIT_MULT before MULT_TIMEOUT_SW asserts.
- CNT_W, 8: width of the saturating wait-cycle counter; must satisfy 2^CNT_W-1 >= MULT_TIMEOUT.

Ports:
- clk  in  1  core clock
- reset_n  in  1  reset; one clock, reset synchronous and active-low
- MEM2WBK_EMPTY_SM  in  1  mem2wbk FIFO empty
- MEM_RES_RM  in  32  head result (ALU or load data)
- MEM_DEST_RM  in  6  head destination register
- WB_RM  in  1  head requires register write
- CSR_WENABLE_RM  in  1  head is a CSR access; rd receives the old CSR value
- CSR_RDATA_RM  in  32  old CSR value
- MULT_INST_RM  in  1  head result comes from the multiplier FIFO
- MEM2WBK_POP_SW  out  1  pop mem2wbk head
- MULT_EMPTY_SX  in  1  multiplier result FIFO empty
- MULT_RES_RX  in  32  multiplier FIFO head
- MULT_POP_SW  out  1  pop multiplier FIFO
- FLUSH_SI  in  1  exception/MRET flush from CSR unit
- WBK_DATA_SW  out  32  register-file write data (registered)
- WBK_DEST_SW  out  6  register-file write address (registered)
- WBK_WB_SW  out  1  register-file write enable (registered)
- WBK_STALL_SW  out  1  head blocked waiting on multiplier (combinational)
- MULT_TIMEOUT_SW  out  1  sticky watchdog flag
- MINSTRET_SW  out  64  retired instruction count

Behaviour:
- Reset (reset_n low at posedge):
  - all outputs and registers go to 0; FSM goes to RUN.
  - MEM2WBK_POP_SW and MULT_POP_SW are forced 0 during reset.
- Head valid: hv = !MEM2WBK_EMPTY_SM.
- Non-mult head (MULT_INST_RM=0): retire in the same cycle.
  - MEM2WBK_POP_SW=1, MULT_POP_SW=0.
- Mult head (MULT_INST_RM=1):
  - retires only when MULT_EMPTY_SX=0; then MEM2WBK_POP_SW=1 and MULT_POP_SW=1 in the same cycle.
  - otherwise neither FIFO is popped and WBK_STALL_SW=1.
- Pops are combinational from the FIFO flags. There is no internal data buffering; retire is exactly the pop cycle.
- Write data selection at retire, in priority order:
  - CSR_WENABLE_RM=1 -> CSR_RDATA_RM
  - else MULT_INST_RM=1 -> MULT_RES_RX
  - else -> MEM_RES_RM
- Registered write port (latency 1): on the edge after retire,
  - WBK_DATA_SW and WBK_DEST_SW load the selected data and MEM_DEST_RM;
  - WBK_WB_SW = (WB_RM | CSR_WENABLE_RM) & (MEM_DEST_RM != 0).
  - With no retire, WBK_WB_SW=0 and data/dest hold their previous values.
- FSM states RUN and WAIT_MULT:
  - RUN -> WAIT_MULT: hv & MULT_INST_RM & MULT_EMPTY_SX.
  - WAIT_MULT -> RUN: the multiplier FIFO becomes non-empty (the retire happens in that cycle), or FLUSH_SI.
  - WAIT_MULT with MEM2WBK_EMPTY_SM=1 must not occur; if it does, return to RUN.
- Wait counter:
  - cleared on entry to WAIT_MULT; increments each cycle in WAIT_MULT; saturates at all-ones.
  - MULT_TIMEOUT_SW sets when the counter equals MULT_TIMEOUT-1 while still in WAIT_MULT.
  - MULT_TIMEOUT_SW is sticky; cleared only by reset or FLUSH_SI.
- FLUSH_SI=1:
  - no pop and no retire that cycle; WBK_WB_SW=0 on the next edge; FSM to RUN; wait counter and timeout cleared.
  - FIFO contents are left intact; the producer side owns the flush.
- MINSTRET_SW:
  - +1 on each retire, including writes to x0 and entries with WB_RM=0.
  - wraps 0xFFFFFFFF_FFFFFFFF -> 0; not incremented in a flush cycle.
- Simultaneous events:
  - The multiplier becoming non-empty in the same cycle the counter reaches timeout: retire takes priority and the flag is not set.
  - FLUSH_SI dominates retire.
- Back-to-back: one retire per cycle sustained while both FIFOs are non-empty.

Test Plan:
- Reset then push ALU entry (RES=0x0000_1234, DEST=5, WB=1): pop same cycle -> next cycle WBK_WB_SW=1, DEST=5, DATA=0x1234; MINSTRET_SW=1.
- Mult head DEST=7 with MULT_EMPTY_SX=1 for 3 cycles, then MULT_RES_RX=0xDEAD_BEEF arrives:
  - WBK_STALL_SW=1 for 3 cycles, no pops;
  - both pops in cycle 4; DATA=0xDEADBEEF, DEST=7 one cycle later.
- CSR head (CSR_WENABLE=1, CSR_RDATA=0x1800, RES=0x55, DEST=3) -> DATA=0x1800. Same entry with DEST=0 -> WBK_WB_SW=0 but MINSTRET_SW increments.
- Mult starvation with MULT_TIMEOUT=4 -> MULT_TIMEOUT_SW=1 from the 4th WAIT_MULT cycle and held; FLUSH_SI pulse -> flag 0, FSM RUN, no pop that cycle.
- Preload MINSTRET to 0xFFFFFFFF_FFFFFFFF via 2^64-1-equivalent force, retire one -> 0. Apply reset mid-WAIT_MULT -> all outputs 0 on the next edge, pops 0.
- 10 alternating ALU/mult entries, both FIFOs always non-empty -> 10 retires in 10 consecutive cycles, write order preserved, MINSTRET_SW=10.
